// File: rtl/countdown_timer_bank_pkg.sv
// Shared constants, types and field-wrap helpers for the countdown timer bank.
// Field arithmetic is done on 7-bit values and range-checked before truncation.
package countdown_timer_bank_pkg;

    localparam int KILO = 1000;

    localparam logic [1:0] SELECT_SEC  = 2'd0;
    localparam logic [1:0] SELECT_MIN  = 2'd1;
    localparam logic [1:0] SELECT_HOUR = 2'd2;

    localparam logic [1:0] TMR_IDLE = 2'd0;
    localparam logic [1:0] TMR_RUN  = 2'd1;
    localparam logic [1:0] TMR_EXP  = 2'd2;

    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
        logic [6:0] t;
        t = v + 7'd1;
        return (t > max) ? 7'd0 : t;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] max);
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

endpackage

// File: rtl/countdown_timer_bank_if.sv
// Control/status bundle between the timer bank and its user (edit panel, display mux).
interface countdown_timer_bank_if #(parameter int NUM_CH = 4);
    import countdown_timer_bank_pkg::*;

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] run;
    logic [CH_W-1:0]   edit_ch;
    logic [1:0]        select;
    logic              increment;
    logic              decrement;
    logic [5:0]        sec_out;
    logic [5:0]        min_out;
    logic [4:0]        hour_out;
    logic [NUM_CH-1:0] expired;
    logic              any_expired;

    modport master (
        output run, edit_ch, select, increment, decrement,
        input  sec_out, min_out, hour_out, expired, any_expired
    );

    modport slave (
        input  run, edit_ch, select, increment, decrement,
        output sec_out, min_out, hour_out, expired, any_expired
    );

endinterface

// File: rtl/countdown_timer_bank_timer_channel.sv
// One HH:MM:SS countdown channel: IDLE/RUNNING/EXPIRED FSM, field edits and borrow decrement.
// TIMER_AUTO_RELOAD_EN adds a preset that reloads on expiry instead of going sticky.
module countdown_timer_bank_timer_channel
    import countdown_timer_bank_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       run,
    input  logic       edit_en,
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] select,
    output hms_t       time_out,
    output logic       expired
);

    logic [1:0] state_q, state_d;
    hms_t       time_q, time_d, edit_t, dec_t;
    logic       expired_q, expired_d;
`ifdef TIMER_AUTO_RELOAD_EN
    hms_t       preset_q, preset_d;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        edit_t = time_q;
        if (edit_en && (inc ^ dec)) begin
            case (select)
                SELECT_SEC:  edit_t.sec  = 6'(inc ? wrap_inc({1'b0, time_q.sec}, SEC_MAX)
                                                  : wrap_dec({1'b0, time_q.sec}, SEC_MAX));
                SELECT_MIN:  edit_t.min  = 6'(inc ? wrap_inc({1'b0, time_q.min}, MIN_MAX)
                                                  : wrap_dec({1'b0, time_q.min}, MIN_MAX));
                SELECT_HOUR: edit_t.hour = 5'(inc ? wrap_inc({2'b00, time_q.hour}, HOUR_MAX)
                                                  : wrap_dec({2'b00, time_q.hour}, HOUR_MAX));
                default: ;
            endcase
        end
    end

    // Borrow chain; only meaningful when time_q is non-zero, so hour never underflows.
    always_comb begin
        dec_t     = time_q;
        dec_t.sec = 6'(wrap_dec({1'b0, time_q.sec}, SEC_MAX));
        if (time_q.sec == 6'd0) begin
            dec_t.min = 6'(wrap_dec({1'b0, time_q.min}, MIN_MAX));
            if (time_q.min == 6'd0)
                dec_t.hour = 5'(wrap_dec({2'b00, time_q.hour}, HOUR_MAX));
        end
    end

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        expired_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        preset_d  = preset_q;
`endif
        case (state_q)
            TMR_IDLE: begin
                time_d = edit_t;
                if (run) begin
                    state_d = TMR_RUN;
`ifdef TIMER_AUTO_RELOAD_EN
                    preset_d = edit_t;
`endif
                end
            end
            TMR_RUN: begin
                if (!run) begin
                    state_d = TMR_IDLE;
                end else if (tick) begin
                    if ((time_q == '0) || (dec_t == '0)) begin
                        expired_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                        time_d    = preset_q;
`else
                        time_d    = '0;
                        state_d   = TMR_EXP;
`endif
                    end else begin
                        time_d = dec_t;
                    end
                end
            end
            TMR_EXP: begin
                if (!run) state_d = TMR_IDLE;
                else      expired_d = 1'b1;
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= TMR_IDLE;
            time_q    <= '0;
            expired_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            expired_q <= expired_d;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    assign time_out = time_q;
    assign expired  = expired_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of NUM_CH HH:MM:SS countdown timers with a shared 1 Hz prescaler and edit port.
// Optional TIMER_AUTO_RELOAD_EN makes each channel reload its start time on expiry.
module countdown_timer_bank
    import countdown_timer_bank_pkg::*;
#(
    parameter int CLK_FREQ_HZ = KILO,
    parameter int NUM_CH      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    countdown_timer_bank_if.slave  bus
);

    localparam int              CH_W    = ch_width(NUM_CH);
    localparam int              PS_W    = $clog2(CLK_FREQ_HZ);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ_HZ - 1);

    logic [PS_W-1:0]   ps_q;
    logic              tick;
    logic              any_run;
    logic              inc_q, dec_q, inc_p, dec_p;
    hms_t              ch_time [NUM_CH];
    logic [NUM_CH-1:0] ch_expired;
    hms_t              view;

    assign any_run = |bus.run;
    assign tick    = any_run && (ps_q == PS_LAST);

    // Held at zero while nothing runs so the first tick lands a full period after start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        ps_q <= '0;
        else if (!any_run || ps_q == PS_LAST) ps_q <= '0;
        else                                 ps_q <= ps_q + PS_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= bus.increment;
            dec_q <= bus.decrement;
        end
    end

    assign inc_p = bus.increment & ~inc_q;
    assign dec_p = bus.decrement & ~dec_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        countdown_timer_bank_timer_channel u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .run      (bus.run[i]),
            .edit_en  (bus.edit_ch == CH_W'(i)),
            .inc      (inc_p),
            .dec      (dec_p),
            .select   (bus.select),
            .time_out (ch_time[i]),
            .expired  (ch_expired[i])
        );
    end

    // Codes at or beyond NUM_CH match no channel and show 00:00:00.
    always_comb begin
        view = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.edit_ch == CH_W'(i)) view = ch_time[i];
    end

    assign bus.sec_out     = view.sec;
    assign bus.min_out     = view.min;
    assign bus.hour_out    = view.hour;
    assign bus.expired     = ch_expired;
    assign bus.any_expired = |ch_expired;

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed bench for countdown_timer_bank with CLK_FREQ_HZ=4, NUM_CH=2.
module tb_countdown_timer_bank;
    import countdown_timer_bank_pkg::*;

    localparam int NUM_CH = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    countdown_timer_bank_if #(.NUM_CH(NUM_CH)) bus_if ();

    countdown_timer_bank #(.CLK_FREQ_HZ(4), .NUM_CH(NUM_CH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [16:0] view();
        return {bus_if.hour_out, bus_if.min_out, bus_if.sec_out};
    endfunction

    function automatic string fmt(input logic [16:0] v);
        return $sformatf("%0d:%0d:%0d", v[16:12], v[11:6], v[5:0]);
    endfunction

    task automatic do_reset();
        reset_n          = 1'b0;
        bus_if.run       = '0;
        bus_if.edit_ch   = 1'b0;
        bus_if.select    = SELECT_SEC;
        bus_if.increment = 1'b0;
        bus_if.decrement = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic edit_pulse(input logic ch, input logic [1:0] sel, input logic up, input int n);
        bus_if.edit_ch = ch;
        bus_if.select  = sel;
        for (int i = 0; i < n; i++) begin
            if (up) bus_if.increment = 1'b1;
            else    bus_if.decrement = 1'b1;
            step(1);
            bus_if.increment = 1'b0;
            bus_if.decrement = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL reset_time: got %s want 0:0:0", fmt(view())); end
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL reset_expired: got %b want 00", bus_if.expired); end
        total++; if (bus_if.any_expired !== 1'b0) begin bad++; $display("FAIL reset_any: got %b want 0", bus_if.any_expired); end
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 5);
        bus_if.run = 2'b01;
        step(5);
        total++; if (view() !== hms(0, 0, 4)) begin bad++; $display("FAIL reset_midcount: got %s want 0:0:4", fmt(view())); end
        reset_n = 1'b0;
        #1;
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL reset_async_time: got %s want 0:0:0", fmt(view())); end
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL reset_async_exp: got %b want 00", bus_if.expired); end
        bus_if.run = 2'b00;
        step(2);
        reset_n = 1'b1;
        step(1);
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 3);
        bus_if.run = 2'b01;
        step(3);
        total++; if (view() !== hms(0, 0, 3)) begin bad++; $display("FAIL reset_no_early_tick: got %s want 0:0:3", fmt(view())); end
        step(1);
        total++; if (view() !== hms(0, 0, 2)) begin bad++; $display("FAIL reset_first_tick: got %s want 0:0:2", fmt(view())); end
        bus_if.run = 2'b00;
        step(1);
    endtask

    task automatic test_edit_wrap();
        do_reset();
        edit_pulse(1'b1, SELECT_SEC, 1'b0, 1);
        total++; if (view() !== hms(0, 0, 59)) begin bad++; $display("FAIL edit_sec_dec_wrap: got %s want 0:0:59", fmt(view())); end
        bus_if.edit_ch = 1'b0;
        #1;
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL edit_other_ch: got %s want 0:0:0", fmt(view())); end
        edit_pulse(1'b1, SELECT_HOUR, 1'b0, 1);
        total++; if (view() !== hms(23, 0, 59)) begin bad++; $display("FAIL edit_hour_dec_wrap: got %s want 23:0:59", fmt(view())); end
        edit_pulse(1'b1, SELECT_HOUR, 1'b1, 1);
        total++; if (view() !== hms(0, 0, 59)) begin bad++; $display("FAIL edit_hour_inc_wrap: got %s want 0:0:59", fmt(view())); end
        edit_pulse(1'b1, SELECT_MIN, 1'b0, 1);
        total++; if (view() !== hms(0, 59, 59)) begin bad++; $display("FAIL edit_min_dec_wrap: got %s want 0:59:59", fmt(view())); end
        edit_pulse(1'b1, SELECT_MIN, 1'b1, 1);
        total++; if (view() !== hms(0, 0, 59)) begin bad++; $display("FAIL edit_min_inc_wrap: got %s want 0:0:59", fmt(view())); end
        edit_pulse(1'b1, SELECT_SEC, 1'b1, 1);
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL edit_sec_inc_wrap: got %s want 0:0:0", fmt(view())); end
        bus_if.select    = SELECT_SEC;
        bus_if.increment = 1'b1;
        bus_if.decrement = 1'b1;
        step(1);
        bus_if.increment = 1'b0;
        bus_if.decrement = 1'b0;
        step(1);
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL edit_inc_dec_same: got %s want 0:0:0", fmt(view())); end
        edit_pulse(1'b1, 2'd3, 1'b1, 1);
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL edit_no_field: got %s want 0:0:0", fmt(view())); end
    endtask

    task automatic test_borrow();
        do_reset();
        edit_pulse(1'b0, SELECT_HOUR, 1'b1, 1);
        edit_pulse(1'b1, SELECT_SEC, 1'b1, 7);
        bus_if.edit_ch = 1'b0;
        bus_if.run     = 2'b01;
        step(3);
        total++; if (view() !== hms(1, 0, 0)) begin bad++; $display("FAIL borrow_pre_tick: got %s want 1:0:0", fmt(view())); end
        step(1);
        total++; if (view() !== hms(0, 59, 59)) begin bad++; $display("FAIL borrow_tick: got %s want 0:59:59", fmt(view())); end
        bus_if.edit_ch = 1'b1;
        #1;
        total++; if (view() !== hms(0, 0, 7)) begin bad++; $display("FAIL borrow_ch1_idle: got %s want 0:0:7", fmt(view())); end
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 1);
        total++; if (view() !== hms(0, 59, 59)) begin bad++; $display("FAIL borrow_edit_dropped: got %s want 0:59:59", fmt(view())); end
        step(2);
        total++; if (view() !== hms(0, 59, 58)) begin bad++; $display("FAIL borrow_second_tick: got %s want 0:59:58", fmt(view())); end
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL borrow_not_expired: got %b want 00", bus_if.expired); end
        bus_if.run = 2'b00;
        step(1);
    endtask

`ifndef TIMER_AUTO_RELOAD_EN
    task automatic test_expiry();
        do_reset();
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 2);
        bus_if.run = 2'b01;
        step(7);
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL expiry_early: got %b want 00", bus_if.expired); end
        step(1);
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL expiry_flag: got %b want 01", bus_if.expired); end
        total++; if (bus_if.any_expired !== 1'b1) begin bad++; $display("FAIL expiry_any: got %b want 1", bus_if.any_expired); end
        step(4);
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL expiry_hold_zero: got %s want 0:0:0", fmt(view())); end
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL expiry_sticky: got %b want 01", bus_if.expired); end
        bus_if.run = 2'b00;
        step(1);
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL expiry_clear: got %b want 00", bus_if.expired); end
        total++; if (bus_if.any_expired !== 1'b0) begin bad++; $display("FAIL expiry_any_clear: got %b want 0", bus_if.any_expired); end
        bus_if.run = 2'b01;
        step(3);
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL expiry_zero_early: got %b want 00", bus_if.expired); end
        step(1);
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL expiry_zero_tick1: got %b want 01", bus_if.expired); end
        bus_if.run = 2'b00;
        step(1);
    endtask
`else
    task automatic test_auto_reload();
        do_reset();
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 3);
        bus_if.run = 2'b01;
        step(11);
        total++; if (view() !== hms(0, 0, 1)) begin bad++; $display("FAIL reload_count: got %s want 0:0:1", fmt(view())); end
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL reload_early: got %b want 00", bus_if.expired); end
        step(1);
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL reload_pulse1: got %b want 01", bus_if.expired); end
        total++; if (view() !== hms(0, 0, 3)) begin bad++; $display("FAIL reload_value: got %s want 0:0:3", fmt(view())); end
        step(1);
        total++; if (bus_if.expired !== 2'b00) begin bad++; $display("FAIL reload_not_sticky: got %b want 00", bus_if.expired); end
        step(11);
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL reload_pulse2: got %b want 01", bus_if.expired); end
        total++; if (view() !== hms(0, 0, 3)) begin bad++; $display("FAIL reload_value2: got %s want 0:0:3", fmt(view())); end
        bus_if.run = 2'b00;
        step(1);
    endtask
`endif

    task automatic test_pause();
        do_reset();
        edit_pulse(1'b0, SELECT_SEC, 1'b1, 10);
        bus_if.run = 2'b01;
        step(12);
        total++; if (view() !== hms(0, 0, 7)) begin bad++; $display("FAIL pause_three_ticks: got %s want 0:0:7", fmt(view())); end
        bus_if.run = 2'b00;
        step(5);
        total++; if (view() !== hms(0, 0, 7)) begin bad++; $display("FAIL pause_hold: got %s want 0:0:7", fmt(view())); end
        bus_if.run = 2'b01;
        step(3);
        total++; if (view() !== hms(0, 0, 7)) begin bad++; $display("FAIL pause_resume_early: got %s want 0:0:7", fmt(view())); end
        step(1);
        total++; if (view() !== hms(0, 0, 6)) begin bad++; $display("FAIL pause_resume_tick: got %s want 0:0:6", fmt(view())); end
        bus_if.run = 2'b00;
        step(1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_if.edit_ch   = 1'b0;
        bus_if.select    = SELECT_SEC;
        bus_if.increment = 1'b1;
        bus_if.run       = 2'b01;
        step(1);
        bus_if.increment = 1'b0;
        total++; if (view() !== hms(0, 0, 1)) begin bad++; $display("FAIL b2b_edit_applied: got %s want 0:0:1", fmt(view())); end
        step(3);
        total++; if (bus_if.expired !== 2'b01) begin bad++; $display("FAIL b2b_running_expiry: got %b want 01", bus_if.expired); end
`ifdef TIMER_AUTO_RELOAD_EN
        total++; if (view() !== hms(0, 0, 1)) begin bad++; $display("FAIL b2b_preset_reload: got %s want 0:0:1", fmt(view())); end
`else
        total++; if (view() !== hms(0, 0, 0)) begin bad++; $display("FAIL b2b_expired_time: got %s want 0:0:0", fmt(view())); end
`endif
        bus_if.run = 2'b00;
        step(1);
    endtask

    initial begin
        test_reset();
        test_edit_wrap();
        test_borrow();
`ifndef TIMER_AUTO_RELOAD_EN
        test_expiry();
`else
        test_auto_reload();
`endif
        test_pause();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
